// File: rtl/fpga_config_loader.sv
// Streams bitstream words into NUM_CHAINS parallel tile shift chains and
// pulses the chain set line once CHAIN_LEN shift cycles have been issued.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting words and shifting buffered beats into the chains
// SET    | one-cycle commit pulse on set_out
// DONE   | load committed; waiting for start
module fpga_config_loader #(
    parameter int NUM_CHAINS = 4,
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [WORD_W-1:0]                    cfg_data,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    output logic [NUM_CHAINS-1:0]                shift_out,
    output logic                                 cen_out,
    output logic                                 set_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]       shift_count
);
    localparam int BEATS  = WORD_W / NUM_CHAINS;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SET  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [WORD_W-1:0]     r_buf;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_full;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_ready;
    logic                  w_xfer;
    logic [NUM_CHAINS-1:0] w_beat_bits;

    assign w_load  = (r_state == S_LOAD);
    assign w_shift = w_load && r_full;
    // A new word may land in the same cycle the last beat of the current one
    // shifts, except on the final shift of the load.
    assign w_ready = w_load && (!r_full || (r_beat == LAST_BEAT && r_cnt < LAST_CNT));
    assign w_xfer  = cfg_valid && w_ready;

    always_comb begin
        w_beat_bits = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == BEAT_W'(b)) begin
                w_beat_bits = r_buf[b*NUM_CHAINS +: NUM_CHAINS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_beat  <= '0;
            r_full  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_buf   <= '0;
                        r_beat  <= '0;
                        r_full  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_buf   <= '0;
                        r_beat  <= '0;
                        r_full  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        if (r_full) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == LAST_CNT) begin
                                // Ragged tail: leftover beats are dropped.
                                r_state <= S_SET;
                                r_buf   <= '0;
                                r_beat  <= '0;
                                r_full  <= 1'b0;
                            end else if (r_beat == LAST_BEAT) begin
                                r_beat <= '0;
                                r_full <= 1'b0;
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end
                        if (w_xfer) begin
                            r_buf  <= cfg_data;
                            r_beat <= '0;
                            r_full <= 1'b1;
                        end
                    end
                end
                S_SET: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_buf   <= '0;
                        r_beat  <= '0;
                        r_full  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready   = w_ready;
    assign cen_out     = w_shift;
    assign shift_out   = w_shift ? w_beat_bits : '0;
    assign set_out     = (r_state == S_SET);
    assign busy        = (r_state == S_LOAD) || (r_state == S_SET);
    assign done        = (r_state == S_DONE);
    assign shift_count = r_cnt;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: two instances (CHAIN_LEN 6 and 5)
// on a 4-chain, 8-bit-word configuration, checked cycle by cycle.
module tb_fpga_config_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;

    logic       rdy6, cen6, set6, busy6, done6;
    logic [3:0] sh6;
    logic [2:0] cnt6;
    logic       rdy5, cen5, set5, busy5, done5;
    logic [3:0] sh5;
    logic [2:0] cnt5;

    int n_cmp = 0;
    int n_bad = 0;
    int widx  = 0;

    logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hF0};

    // {busy, done, set, cen, shift[3:0]} per cycle after the start edge
    logic [7:0] t1 [12] = '{8'h80, 8'h95, 8'h9A, 8'h9C, 8'h93, 8'h90,
                            8'h9F, 8'hA0, 8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] t2 [12] = '{8'h80, 8'h95, 8'h9A, 8'h9C, 8'h93, 8'h90,
                            8'hA0, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] t3 [12] = '{8'h80, 8'h95, 8'h9A, 8'h80, 8'h80, 8'h80,
                            8'h9C, 8'h93, 8'h90, 8'h9F, 8'hA0, 8'h40};
    logic [7:0] t4 [12] = '{8'h80, 8'h95, 8'h9A, 8'h9C, 8'h93, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    fpga_config_loader #(.NUM_CHAINS(4), .WORD_W(8), .CHAIN_LEN(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy6),
        .shift_out(sh6), .cen_out(cen6), .set_out(set6), .busy(busy6),
        .done(done6), .shift_count(cnt6)
    );

    fpga_config_loader #(.NUM_CHAINS(4), .WORD_W(8), .CHAIN_LEN(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy5),
        .shift_out(sh5), .cen_out(cen5), .set_out(set5), .busy(busy5),
        .done(done5), .shift_count(cnt5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input bit sel5);
        if (sel5) return {24'd0, busy5, done5, set5, cen5, sh5};
        return {24'd0, busy6, done6, set6, cen6, sh6};
    endfunction

    function automatic logic [31:0] rst_pack(input bit sel5);
        if (sel5) return {20'd0, rdy5, busy5, done5, set5, cen5, sh5, cnt5};
        return {20'd0, rdy6, busy6, done6, set6, cen6, sh6, cnt6};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input string tag, input bit sel5, input logic [7:0] exp [12],
                            input int stall_lo, input int stall_hi, input int abort_at,
                            input int start_at, input int rdy0_at, input int cnt_at,
                            input logic [2:0] cnt_exp);
        logic hs;
        widx  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_cyc%0d", tag, i), obs_of(sel5), {24'd0, exp[i]});
            if (i == rdy0_at)
                chk($sformatf("%s_ready%0d", tag, i), {31'd0, sel5 ? rdy5 : rdy6}, 32'd0);
            if (i == cnt_at)
                chk($sformatf("%s_count%0d", tag, i), {29'd0, sel5 ? cnt5 : cnt6}, {29'd0, cnt_exp});
            cfg_valid = (widx < 3) && !(i >= stall_lo && i <= stall_hi);
            cfg_data  = (cfg_valid && widx < 3) ? words[widx] : 8'h00;
            abort     = (i == abort_at);
            start     = (i == start_at);
            hs        = cfg_valid && (sel5 ? rdy5 : rdy6);
            tick();
            if (hs) widx++;
        end
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset6", rst_pack(1'b0), 32'd0);
        chk("reset5", rst_pack(1'b1), 32'd0);
        rst = 1'b0;
        tick();

        run_load("stream6", 1'b0, t1, -1, -1, -1, -1, 6, 11, 3'd6);
        run_load("ignore6", 1'b0, t1, -1, -1, 8, 2, -1, 11, 3'd6);

        do_reset();
        run_load("ragged5", 1'b1, t2, -1, -1, -1, -1, 5, 11, 3'd5);

        do_reset();
        run_load("stall6", 1'b0, t3, 2, 4, -1, -1, -1, 4, 3'd2);

        run_load("abort6", 1'b0, t4, -1, -1, 4, -1, -1, 4, 3'd3);
        run_load("reload6", 1'b0, t1, -1, -1, -1, -1, -1, 0, 3'd0);

        // Reset in the middle of a load, with start and abort also asserted.
        start = 1'b1;
        tick();
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("midload_cen", {31'd0, cen6}, 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("midrst6", rst_pack(1'b0), 32'd0);
        chk("midrst5", rst_pack(1'b1), 32'd0);
        tick();
        chk("midrst6_hold", rst_pack(1'b0), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("post_rst_idle", rst_pack(1'b0), 32'd0);
        run_load("after_rst6", 1'b0, t1, -1, -1, -1, -1, 6, 11, 3'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Parametrised configuration loader for the tile array. It accepts bitstream words over a valid/ready stream and drives NUM_CHAINS tile shift chains in parallel through their `shift_in_hard` inputs, gating shifting with a fabric clock-enable. After exactly CHAIN_LEN shift cycles it pulses the chain `set_in_hard` line to commit the configuration. It sits between the management-side bitstream source and the column heads of the `clb_tile` array, replacing a single hand-driven shift/set pair.

## Interface
Parameters:
- `NUM_CHAINS`, 4: parallel shift chains (array columns); ≥1.
- `WORD_W`, 32: input word width; must be a multiple of NUM_CHAINS.
- `CHAIN_LEN`, 1024: shift cycles per chain per load; ≥1.
- Derived `BEATS` = WORD_W/NUM_CHAINS: shift cycles per word.
- Derived `CNT_W` = $clog2(CHAIN_LEN+1).

Ports:
- `clk`  in  1  fabric/config clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled in IDLE or DONE.
- `abort`  in  1  cancel an in-progress load.
- `cfg_data`  in  WORD_W  bitstream word.
- `cfg_valid`  in  1  cfg_data valid.
- `cfg_ready`  out  1  loader accepts cfg_data this cycle.
- `shift_out`  out  NUM_CHAINS  bit per chain, to tile `shift_in_hard`.
- `cen_out`  out  1  shift enable to the fabric `cen`; chains advance only when high.
- `set_out`  out  1  one-cycle commit pulse, to tile `set_in_hard`.
- `busy`  out  1  state is LOAD or SET.
- `done`  out  1  last load completed without abort.
- `shift_count`  out  CNT_W  shift cycles issued in the current load.

## Operation
- States: IDLE, LOAD, SET, DONE.
- IDLE/DONE + `start` → LOAD. This clears shift_count, the word buffer and `done`.
- Word buffer: a single WORD_W register plus a beat index (0..BEATS-1) and a full flag.
- `cfg_ready` = (state==LOAD) && (!full || (beat==BEATS-1 && shift_count < CHAIN_LEN-1)).
- Handshake: transfer when cfg_valid && cfg_ready. The word loads into the buffer with beat=0 and full=1.
- Shift cycle occurs when state==LOAD && full:
  - `cen_out`=1.
  - `shift_out[c]` = buffer[beat*NUM_CHAINS + c].
  - shift_count increments.
  - beat increments. At BEATS-1, full clears unless a new word is accepted in the same cycle.
- No word buffered in LOAD: `cen_out`=0 and `shift_out`=0. The chains hold state.
- Shift cycle at shift_count==CHAIN_LEN-1 → SET. Beats remaining in the buffer are discarded; this is the ragged tail when CHAIN_LEN is not a multiple of BEATS. `cfg_ready` is 0 during this last shift cycle.
- SET: `set_out`=1 for exactly one cycle, with `cen_out`=0. Next state is DONE.
- DONE: `done`=1 and `cfg_ready`=0. Stays until `start` or `rst`.
- `abort` in LOAD or SET → IDLE at the next edge. No `set_out` pulse, `done`=0, buffer cleared. `abort` has priority over a handshake and a shift in the same cycle. `abort` in IDLE or DONE is ignored.
- `start` while busy is ignored.
- Words presented outside LOAD are not accepted.

## Timing
- Reset values: state IDLE, `cfg_ready`=0, `shift_out`=0, `cen_out`=0, `set_out`=0, `busy`=0, `done`=0, `shift_count`=0. Reset takes priority over all inputs, including mid-load; no set pulse is emitted.
- `shift_out`, `cen_out` and `set_out` are decoded from registered state only, with no input-to-output combinational path. `cfg_ready` depends on state only.
- Latency: a word accepted at edge N produces its beat 0 in the cycle after N.
- Sustained throughput with valid held high: `cen_out` stays high continuously (one word per BEATS cycles).
- `start` at edge S: LOAD from S. Shift cycles occupy CHAIN_LEN cycles, with gaps only from valid stalls. `set_out` is high the cycle after the final shift. `done` rises the cycle after that.
- Total minimum load: 1 + CHAIN_LEN + 1 cycles from the first handshake to `done`.

## Test plan
- NUM_CHAINS=4, WORD_W=8, CHAIN_LEN=6, words 0xA5, 0x3C, 0xF0 streamed back-to-back → `cen_out` high 6 consecutive cycles. `shift_out` sequence is 5, A, C, 3, 0, F. `set_out` pulses once, then `done`=1.
- Same config, CHAIN_LEN=5 → 5 shift cycles (5, A, C, 3, 0). Beat F is discarded. `cfg_ready`=0 after the 3rd word is accepted. `set_out` pulses in the cycle after shift 5.
- `cfg_valid` dropped for 3 cycles after the first word → `cen_out`=0 gap of 3 cycles, `shift_count` frozen at 2. The resumed bit order and final `set_out` are unchanged.
- `abort` asserted when `shift_count`=3 → IDLE next cycle. `cen_out`=0, no `set_out`, `done`=0. A new `start` then loads from `shift_count`=0.
- `rst` asserted mid-load, then a new `start` → all outputs at reset values during reset. The full load afterwards completes correctly.
- `start` pulsed during LOAD and `abort` pulsed in DONE → both ignored. Counts and outputs are unaffected.
